writeback_arbiter: RTL

- Producer side of the decode stage's register-file write port.
- Merges the in-order pipeline writeback with results from long-latency units (divider, FPU) onto the single shared port: reg_write, reg_write_float, write_id, write_data.
- Pipeline writes always win. Long-latency results are buffered in a small FIFO and drained in free cycles.
- Drives a hazard flag so decode can stall on reads of still-queued destinations, and a stall request to break starvation.

---
 rtl/writeback_arbiter_if.sv | 50 +++++
 rtl/writeback_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_if
//   Bundles the signals of the register-file writeback arbiter.
//   Modport slave  : the arbiter's view (receives pipeline / long-latency
//                    results and decode sources, drives the shared write port,
//                    hazard and stall request).
//   Modport master : the surrounding pipeline's view (mirror of slave).
//   Signals:
//     wb_reg_write, wb_reg_write_float, wb_id[4:0], wb_data[31:0] : pipeline wb
//     lu_valid, lu_ready, lu_float, lu_id[4:0], lu_data[31:0]     : long-latency
//     rs1[4:0], rs2[4:0], rs_float, hazard                        : decode check
//     stall_req                                                   : starvation
//     reg_write, reg_write_float, write_id[4:0], write_data[31:0] : write port
// -----------------------------------------------------------------------------
interface writeback_arbiter_if;
  logic        wb_reg_write;
  logic        wb_reg_write_float;
  logic [4:0]  wb_id;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic        lu_float;
  logic [4:0]  lu_id;
  logic [31:0] lu_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs_float;
  logic        hazard;
  logic        stall_req;
  logic        reg_write;
  logic        reg_write_float;
  logic [4:0]  write_id;
  logic [31:0] write_data;

  modport slave (
    input  wb_reg_write, wb_reg_write_float, wb_id, wb_data,
    input  lu_valid, lu_float, lu_id, lu_data,
    input  rs1, rs2, rs_float,
    output lu_ready, hazard, stall_req,
    output reg_write, reg_write_float, write_id, write_data
  );

  modport master (
    output wb_reg_write, wb_reg_write_float, wb_id, wb_data,
    output lu_valid, lu_float, lu_id, lu_data,
    output rs1, rs2, rs_float,
    input  lu_ready, hazard, stall_req,
    input  reg_write, reg_write_float, write_id, write_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Drives the single register-file write port. In-order pipeline writebacks
//   always win; results from long-latency units are queued in a small FIFO and
//   drained on cycles the pipeline leaves free. Flags decode hazards on queued
//   destinations and requests a writeback bubble when the queue is starved.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   STARVE_LIMIT consecutive blocked cycles before stall_req asserts
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  writeback_arbiter_if.slave (see interface for the signal list)
//
// Optional feature (macro WB_ARB_BYPASS_EN):
//   Defined   : with an empty FIFO and no pipeline write, an lu result goes
//               straight to the output register (latency 1, never queued).
//   Undefined : every lu result is queued (minimum latency 2).
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                rst,
  writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == LIMIT) ? v : v + CW'(1);
  endfunction

  // FIFO storage (data only, no reset) and control state
  logic [31:0]   mem_data [DEPTH];
  logic [4:0]    mem_id   [DEPTH];
  logic          mem_flt  [DEPTH];
  logic [AW:0]   rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          empty, full;
  logic [CW-1:0] starve_cnt;

  assign rd_idx = rd_ptr[AW-1:0];
  assign wr_idx = wr_ptr[AW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_idx == wr_idx) && (rd_ptr[AW] != wr_ptr[AW]);

  assign bus.lu_ready  = !full;
  assign bus.stall_req = (starve_cnt == LIMIT);

  // Stage p0: selection and FIFO handshake decisions
  logic        wb_any_p0, lu_acc_p0, lu_x0_p0, byp_p0, push_p0, pop_p0;
  logic        sel_int_p0, sel_flt_p0, load_p0;
  logic [4:0]  sel_id_p0;
  logic [31:0] sel_data_p0;

  assign wb_any_p0 = bus.wb_reg_write || bus.wb_reg_write_float;
  assign lu_acc_p0 = bus.lu_valid && !full;
  // Integer x0 results complete the handshake but are discarded.
  assign lu_x0_p0  = !bus.lu_float && (bus.lu_id == 5'd0);
`ifdef WB_ARB_BYPASS_EN
  assign byp_p0    = !wb_any_p0 && empty && bus.lu_valid;
`else
  assign byp_p0    = 1'b0;
`endif
  assign pop_p0    = !wb_any_p0 && !empty;
  assign push_p0   = lu_acc_p0 && !lu_x0_p0 && !byp_p0;

  always_comb begin
    sel_int_p0  = 1'b0;
    sel_flt_p0  = 1'b0;
    sel_id_p0   = '0;
    sel_data_p0 = '0;
    if (wb_any_p0) begin
      sel_flt_p0  = bus.wb_reg_write_float;
      sel_int_p0  = bus.wb_reg_write && (bus.wb_id != 5'd0);
      sel_id_p0   = bus.wb_id;
      sel_data_p0 = bus.wb_data;
    end else if (!empty) begin
      sel_flt_p0  = mem_flt[rd_idx];
      sel_int_p0  = !mem_flt[rd_idx];
      sel_id_p0   = mem_id[rd_idx];
      sel_data_p0 = mem_data[rd_idx];
    end else if (byp_p0) begin
      sel_flt_p0  = bus.lu_float;
      sel_int_p0  = !lu_x0_p0 && !bus.lu_float;
      sel_id_p0   = bus.lu_id;
      sel_data_p0 = bus.lu_data;
    end
  end

  // A dropped x0 write leaves id/data holding like an idle cycle.
  assign load_p0 = sel_int_p0 || sel_flt_p0;

  // Hazard: scan only occupied slots (offset from head below count).
  logic          hazard_c;
  logic [AW-1:0] slot, offs;
  always_comb begin
    hazard_c = 1'b0;
    slot     = '0;
    offs     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = AW'(i);
      offs = slot - rd_idx;
      if (({1'b0, offs} < count) &&
          (mem_flt[slot] == bus.rs_float) &&
          (mem_flt[slot] || (mem_id[slot] != 5'd0)) &&
          ((mem_id[slot] == bus.rs1) || (mem_id[slot] == bus.rs2)))
        hazard_c = 1'b1;
    end
  end
  assign bus.hazard = hazard_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (pop_p0)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_p0) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (!empty && wb_any_p0) starve_cnt <= sat_inc(starve_cnt);
      else                     starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_data[wr_idx] <= bus.lu_data;
      mem_id[wr_idx]   <= bus.lu_id;
      mem_flt[wr_idx]  <= bus.lu_float;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_write       <= 1'b0;
      bus.reg_write_float <= 1'b0;
      bus.write_id        <= '0;
      bus.write_data      <= '0;
    end else begin
      bus.reg_write       <= sel_int_p0;
      bus.reg_write_float <= sel_flt_p0;
      if (load_p0) begin
        bus.write_id   <= sel_id_p0;
        bus.write_data <= sel_data_p0;
      end
    end
  end
endmodule
